// File: rtl/mmc1_regs_if.sv
// CPU-side bus and decoded bank-select outputs of the MMC1 register core.
// The master drives the CPU bus; the slave (mmc1_regs) returns the mapping.
interface mmc1_regs_if #(
    parameter int unsigned PRG_ROM_DEPTH = 17
);
    logic                     m2;
    logic [14:0]              cpu_addr;
    logic [7:0]               cpu_data_i;
    logic                     cpu_rw;
    logic                     romsel;
    logic [PRG_ROM_DEPTH-1:0] prg_rom_addr;
    logic                     prg_ram_ce;
    logic [4:0]               chr_bank_lo;
    logic [4:0]               chr_bank_hi;
    logic [1:0]               mirror;
    logic                     reg_load;

    modport master (
        output m2, cpu_addr, cpu_data_i, cpu_rw, romsel,
        input  prg_rom_addr, prg_ram_ce, chr_bank_lo, chr_bank_hi, mirror, reg_load
    );

    modport slave (
        input  m2, cpu_addr, cpu_data_i, cpu_rw, romsel,
        output prg_rom_addr, prg_ram_ce, chr_bank_lo, chr_bank_hi, mirror, reg_load
    );
endinterface

// File: rtl/mmc1_regs.sv
// MMC1 serial-port register file and PRG/CHR bank decode.
// Five LSB-first writes to $8000-$FFFF load one of ctrl/chr0/chr1/prg.
module mmc1_regs #(
    parameter int unsigned PRG_ROM_DEPTH = 17
) (
    input  logic        clk_cpu,
    input  logic        rst,
    mmc1_regs_if.slave  bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BANK_W = PRG_ROM_DEPTH - 14;
    localparam logic [REG_W-1:0] SR_EMPTY   = 5'b10000;
    localparam logic [REG_W-1:0] CTRL_RESET = 5'b01100;

    logic             rom_wr;
    logic             accept;
    logic             wr_prev_q;
    logic [REG_W-1:0] sr_q, sr_d;
    logic [REG_W-1:0] ctrl_q, ctrl_d;
    logic [REG_W-1:0] chr0_q, chr0_d;
    logic [REG_W-1:0] chr1_q, chr1_d;
    logic [REG_W-1:0] prg_q, prg_d;
    logic             reg_load_q, reg_load_d;
    logic [REG_W-1:0] shift_val;
    logic [3:0]       bank16;
    logic             unused_bits;

    // Only the first cycle of a write burst counts, which also swallows RMW double writes.
    assign rom_wr = bus.m2 & ~bus.romsel & ~bus.cpu_rw;
    assign accept = rom_wr & ~wr_prev_q;
    assign shift_val = {bus.cpu_data_i[0], sr_q[REG_W-1:1]};

    always_comb begin
        sr_d       = sr_q;
        ctrl_d     = ctrl_q;
        chr0_d     = chr0_q;
        chr1_d     = chr1_q;
        prg_d      = prg_q;
        reg_load_d = 1'b0;
        if (accept) begin
            if (bus.cpu_data_i[7]) begin
                sr_d        = SR_EMPTY;
                ctrl_d[3:2] = 2'b11;
            end else if (!sr_q[0]) begin
                sr_d = shift_val;
            end else begin
                // Marker bit reached sr[0]: this is the fifth bit.
                sr_d       = SR_EMPTY;
                reg_load_d = 1'b1;
                case (bus.cpu_addr[14:13])
                    2'd0: ctrl_d = shift_val;
                    2'd1: chr0_d = shift_val;
                    2'd2: chr1_d = shift_val;
                    2'd3: prg_d  = shift_val;
                endcase
            end
        end
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            wr_prev_q  <= 1'b0;
            sr_q       <= SR_EMPTY;
            ctrl_q     <= CTRL_RESET;
            chr0_q     <= '0;
            chr1_q     <= '0;
            prg_q      <= '0;
            reg_load_q <= 1'b0;
        end else begin
            wr_prev_q  <= rom_wr;
            sr_q       <= sr_d;
            ctrl_q     <= ctrl_d;
            chr0_q     <= chr0_d;
            chr1_q     <= chr1_d;
            prg_q      <= prg_d;
            reg_load_q <= reg_load_d;
        end
    end

    // All-ones truncated to BANK_W bits is the last 16 KB bank.
    always_comb begin
        bank16 = {prg_q[3:1], bus.cpu_addr[14]};
        case (ctrl_q[3:2])
            2'd2:    bank16 = bus.cpu_addr[14] ? prg_q[3:0] : 4'd0;
            2'd3:    bank16 = bus.cpu_addr[14] ? 4'hF : prg_q[3:0];
            default: bank16 = {prg_q[3:1], bus.cpu_addr[14]};
        endcase
    end

    assign bus.prg_rom_addr = {bank16[BANK_W-1:0], bus.cpu_addr[13:0]};
    assign bus.prg_ram_ce   = bus.m2 & bus.romsel & (bus.cpu_addr[14:13] == 2'b11) & ~prg_q[4];
    assign bus.mirror       = ctrl_q[1:0];
    assign bus.chr_bank_lo  = ctrl_q[4] ? chr0_q : {chr0_q[4:1], 1'b0};
    assign bus.chr_bank_hi  = ctrl_q[4] ? chr1_q : {chr0_q[4:1], 1'b1};
    assign bus.reg_load     = reg_load_q;

    assign unused_bits = ^{bus.cpu_data_i[6:1], bank16};
endmodule

// File: doc/mmc1_regs.md
# mmc1_regs

MMC1 (mapper 001) register and bank-select core, sitting directly below the per-game cart wrappers inside the mapper-001 cart. It decodes CPU writes to $8000-$FFFF through the MMC1 5-bit serial port and holds the control, CHR and PRG bank registers. From those registers it drives the PRG ROM byte address, the PRG RAM enable, and the CHR bank and mirroring selects that the cart's memory and CIRAM logic consume.

## Interface
Parameters:
- PRG_ROM_DEPTH, 17: log2 of PRG ROM bytes, range 15..18; sets the width of prg_rom_addr.

Ports:
- clk_cpu  in  1  CPU clock, the block's only clock.
- rst  in  1  reset; asynchronous, active-high.
- m2  in  1  CPU phi2; qualifies bus accesses.
- cpu_addr  in  15  CPU A14..A0.
- cpu_data_i  in  8  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- romsel  in  1  active-low /ROMSEL, asserted low for $8000-$FFFF.
- prg_rom_addr  out  PRG_ROM_DEPTH  PRG ROM byte address, combinational.
- prg_ram_ce  out  1  PRG RAM select, combinational.
- chr_bank_lo  out  5  4 KB CHR bank for PPU $0000-$0FFF.
- chr_bank_hi  out  5  4 KB CHR bank for PPU $1000-$1FFF.
- mirror  out  2  0 = one-screen A, 1 = one-screen B, 2 = vertical, 3 = horizontal.
- reg_load  out  1  one-cycle pulse when a fifth bit commits a register.

## Operation
- rom_wr = m2 & ~romsel & ~cpu_rw, sampled on the rising edge of clk_cpu.
- wr_prev flop holds the previous cycle's rom_wr.
- Writes are accepted only when rom_wr & ~wr_prev. The second cycle of a back-to-back pair is ignored, including bit-7 writes. This covers RMW double writes.
- Shift register sr[4:0] uses marker-bit counting and resets to 5'b10000.
- Accepted write with cpu_data_i[7] = 1:
  - sr <= 10000.
  - ctrl[3:2] <= 2'b11; other ctrl bits unchanged.
  - No reg_load pulse.
- Accepted write with cpu_data_i[7] = 0 and sr[0] = 0: sr <= {cpu_data_i[0], sr[4:1]}.
- Accepted write with cpu_data_i[7] = 0 and sr[0] = 1: commit.
  - val = {cpu_data_i[0], sr[4:1]}.
  - Target register is chosen by cpu_addr[14:13]: 0 = ctrl, 1 = chr0, 2 = chr1, 3 = prg.
  - sr <= 10000; reg_load = 1 the following cycle.
- ctrl fields: [1:0] mirror, [3:2] prg_mode, [4] chr_mode.
- prg fields: [3:0] bank, [4] RAM disable (1 = disabled).
- PRG mapping, with b = prg[3:0] and N = 2^(PRG_ROM_DEPTH-14) 16 KB banks:
  - prg_mode 0 or 1: 32 KB mode; bank16 = {b[3:1], cpu_addr[14]}.
  - prg_mode 2: $8000 = bank 0; $C000 = b.
  - prg_mode 3: $8000 = b; $C000 = N-1.
  - prg_rom_addr = {bank16 mod N, cpu_addr[13:0]}; upper bits of bank16 are truncated.
- prg_ram_ce = m2 & romsel & (cpu_addr[14:13] == 2'b11) & ~prg[4].
- CHR mapping:
  - chr_mode 0: chr_bank_lo = {chr0[4:1], 0}; chr_bank_hi = {chr0[4:1], 1}.
  - chr_mode 1: chr_bank_lo = chr0; chr_bank_hi = chr1.
- chr_bank_lo, chr_bank_hi and mirror are decoded only from flops and change only on commits. The PPU-domain consumer may sample them unsynchronized.

## Timing
- Reset values, applied asynchronously:
  - sr = 10000; ctrl = 5'b01100; chr0 = chr1 = prg = 0; wr_prev = 0; reg_load = 0.
  - Hence mirror = 0, chr_bank_lo = 0, chr_bank_hi = 1.
  - With N = 8, prg_rom_addr for $C000 reads maps to bank 7.
- Register updates happen on the accepting edge. Decoded outputs reflect the new value immediately after that edge, a latency of 1 clk_cpu.
- reg_load is high for exactly the one cycle after the committing edge.
- prg_rom_addr and prg_ram_ce follow cpu_addr and m2 combinationally, with zero latency.
- Writes held for multiple cycles with rom_wr high count once.
- Reads (cpu_rw = 1) and writes below $8000 never touch sr.
- Reset asserted mid-sequence discards the partial shift; the next five writes start a fresh sequence.
- A bit-7 write on the fifth write aborts that sequence; nothing is committed.

## Test plan
- Reset release:
  - mirror = 0, chr_bank_lo = 0, chr_bank_hi = 1.
  - cpu_addr = 0x4000 (i.e. $C000) gives prg_rom_addr = 0x1C000; cpu_addr = 0x0000 gives 0x00000 (bank 0 when prg = 0).
- Five isolated writes to $E000 with d0 = 1,0,1,0,0 (value 5) -> prg[3:0] = 5.
  - reg_load pulses once, after the 5th write.
  - cpu_addr = 0x0123 gives prg_rom_addr = 0x14123.
- Write value 0x12 to $8000 (ctrl: mirror 2, mode 0, chr_mode 1), then 7 to $A000 and 9 to $C000.
  - mirror = 2, chr_bank_lo = 7, chr_bank_hi = 9.
  - Changing ctrl to chr_mode 0 gives chr_bank_lo = 6 and chr_bank_hi = 7.
- RMW pattern: two consecutive-cycle writes, repeated five times.
  - Only the first of each pair shifts; commit occurs after 5 pairs.
  - A single held 3-cycle write counts once.
- Three bits written, then a 0x80 write -> sr = 10000 and ctrl[3:2] = 3; five further writes commit normally.
- prg[4] = 1 -> prg_ram_ce stays 0 for $6000 reads. prg[4] = 0 -> prg_ram_ce = 1 for romsel = 1, cpu_addr = 0x6000, m2 = 1.
- Async rst pulse after 4 writes -> registers at reset values; the following write only shifts.
